id_ex_hazard_ctrl: RTL
======================

// Module: id_ex_hazard_ctrl
// PURPOSE
//  Hazard/pipeline-sequencing controller for the ID->EX boundary of the 5-stage RISC-V core.
//  Detects load-use hazards, sequences multi-cycle mul/div stalls and applies branch-mispredict flushes.
//  Drives stall/bubble/flush enables to the PC, the IF/ID register and the ID/EX register,
//  which carries reg_rd_id, read_data1/2, immediate_data, control_signals and branch_out.
// PARAMETERS
//  MULDIV_LAT  4  EX-stage cycles a mul/div occupies (legal 2..16)
//  CNT_W       32 width of the performance counters (used only with HAZARD_PERF_CNT_EN)
// PORTS
//  clk             in   1      core clock, all state on posedge
//  rst             in   1      asynchronous reset, active-high
//  id_rs1          in   5      rs1 index of the instruction in ID
//  id_rs2          in   5      rs2 index of the instruction in ID
//  id_rs1_used     in   1      ID instruction reads rs1
//  id_rs2_used     in   1      ID instruction reads rs2
//  ex_mem_read     in   1      instruction in EX is a load
//  ex_rd           in   5      reg_rd_id of the instruction in EX
//  ex_muldiv_start in   1      mul/div entered EX this cycle
//  ex_mispredict   in   1      EX resolved branch_out as mispredicted
//  pc_stall        out  1      hold PC
//  if_id_stall     out  1      hold the IF/ID register
//  id_ex_stall     out  1      hold the ID/EX register contents
//  id_ex_bubble    out  1      load an all-zero control_signals NOP into ID/EX
//  if_id_flush     out  1      clear IF/ID to NOP
//  id_ex_flush     out  1      clear ID/EX to NOP
//  busy            out  1      FSM is not in RUN
//  stall_cycles    out  CNT_W  cycles in which pc_stall was high
//  flush_count     out  CNT_W  number of mispredict flushes
// BEHAVIOUR
//  - Reset: state=RUN, md_cnt=0, counters=0. While rst=1 every output is 0.
//  - Outputs are combinational from state and inputs, and take effect in the same cycle.
//  - FSM states: RUN, MD_WAIT. md_cnt width = $clog2(MULDIV_LAT).
//  - Per-cycle priority in RUN: mispredict > muldiv_start > load-use.
//    - mispredict: if_id_flush=1, id_ex_flush=1, no stall. State stays RUN. Any coincident hazard is ignored.
//    - muldiv_start (no mispredict): pc_stall=if_id_stall=id_ex_stall=1.
//      Next state MD_WAIT, md_cnt <= MULDIV_LAT-2.
//    - load-use: ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
//      Drives pc_stall=if_id_stall=1, id_ex_bubble=1 for exactly one cycle. State stays RUN.
//      The bubble clears ex_mem_read in the next cycle, so there is no re-trigger.
//    - x0 never creates a hazard.
//  - MD_WAIT: pc_stall=if_id_stall=id_ex_stall=1, busy=1, md_cnt decrements each cycle.
//    - When md_cnt==0, return to RUN.
//    - Total stall across start plus MD_WAIT is MULDIV_LAT-1 cycles; EX then completes the op.
//    - Load-use, muldiv_start and mispredict are ignored in MD_WAIT (EX is frozen).
//      mispredict=1 in MD_WAIT is a protocol error and is checked by an assertion.
//  - id_ex_stall and id_ex_bubble are never both 1. Flushes are never coincident with stalls.
//  - Reset asserted mid-MD_WAIT aborts immediately: state=RUN and outputs 0 asynchronously.
// CONFIGURATION
//  - HAZARD_PERF_CNT_EN defined:
//    - stall_cycles increments every cycle with pc_stall=1.
//    - flush_count increments on every cycle with if_id_flush=1.
//    - Both saturate at 2^CNT_W-1 (no wrap) and reset to 0.
//  - HAZARD_PERF_CNT_EN undefined: no counter flops; stall_cycles and flush_count are tied to 0. The port list is unchanged.
// TESTING
//  - Reset: rst=1 with all inputs toggling -> all outputs 0, busy=0. After deassert, state RUN.
//  - Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1.
//    -> pc_stall, if_id_stall, id_ex_bubble high 1 cycle. With ex_rd=0 -> nothing.
//  - Muldiv: ex_muldiv_start=1 pulse with MULDIV_LAT=4.
//    -> pc_stall/if_id_stall/id_ex_stall high 3 consecutive cycles, busy high last 2, then RUN.
//  - Priority: ex_mispredict=1 with load-use and muldiv_start in the same cycle.
//    -> only if_id_flush and id_ex_flush high, no stall, state RUN.
//  - Mid-op reset: rst pulse in MD_WAIT cycle 2 -> outputs drop async, busy=0. A following load-use is detected normally.
//  - Counters (HAZARD_PERF_CNT_EN, CNT_W=4): 20 stall cycles -> stall_cycles=15 saturated.
//    3 mispredicts -> flush_count=3. Without the macro, both read 0.

Source files
------------

// File: rtl/id_ex_hazard_ctrl_if.sv
// Hazard-control bundle between ID/EX pipeline logic and id_ex_hazard_ctrl.
// master drives hazard sources, slave (the controller) returns enables.
interface id_ex_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_muldiv_start;
  logic             ex_mispredict;
  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_stall;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2,
    output id_rs1_used, id_rs2_used,
    output ex_mem_read, ex_rd,
    output ex_muldiv_start, ex_mispredict,
    input  pc_stall, if_id_stall,
    input  id_ex_stall, id_ex_bubble,
    input  if_id_flush, id_ex_flush,
    input  busy, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2,
    input  id_rs1_used, id_rs2_used,
    input  ex_mem_read, ex_rd,
    input  ex_muldiv_start, ex_mispredict,
    output pc_stall, if_id_stall,
    output id_ex_stall, id_ex_bubble,
    output if_id_flush, id_ex_flush,
    output busy, stall_cycles, flush_count
  );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use bubble, mul/div stall, mispredict flush.
// Optional saturating perf counters enabled by HAZARD_PERF_CNT_EN.
module id_ex_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input logic                clk,
  input logic                rst,
  id_ex_hazard_ctrl_if.slave h
);

  localparam int CW = (MULDIV_LAT > 2) ?
                      $clog2(MULDIV_LAT) : 1;

  typedef enum logic {
    RUN,
    MD_WAIT
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   md_cnt_q;
  logic [CW-1:0]   md_cnt_d;

  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic pc_stall;
  logic if_id_stall;
  logic id_ex_stall;
  logic id_ex_bubble;
  logic if_id_flush;
  logic id_ex_flush;
  logic busy;

  assign rs1_hit = h.id_rs1_used &
                   (h.id_rs1 == h.ex_rd);
  assign rs2_hit = h.id_rs2_used &
                   (h.id_rs2 == h.ex_rd);
  assign load_use = h.ex_mem_read &
                    (h.ex_rd != 5'd0) &
                    (rs1_hit | rs2_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    busy         = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (h.ex_mispredict) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (h.ex_muldiv_start) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            // a 2-cycle op needs only the start-cycle stall
            if (MULDIV_LAT > 2) begin
              state_d  = MD_WAIT;
              md_cnt_d = CW'(MULDIV_LAT - 2);
            end
          end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        MD_WAIT: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          busy        = 1'b1;
          md_cnt_d    = md_cnt_q - CW'(1);
          if (md_cnt_d == '0) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  assign h.pc_stall     = pc_stall;
  assign h.if_id_stall  = if_id_stall;
  assign h.id_ex_stall  = id_ex_stall;
  assign h.id_ex_bubble = id_ex_bubble;
  assign h.if_id_flush  = if_id_flush;
  assign h.id_ex_flush  = id_ex_flush;
  assign h.busy         = busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (pc_stall && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (if_id_flush && (flush_q != '1)) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign h.stall_cycles = stall_q;
  assign h.flush_count  = flush_q;
`else
  assign h.stall_cycles = '0;
  assign h.flush_count  = '0;
`endif

  // EX is frozen during MD_WAIT, so a mispredict there is illegal
  a_no_mp_in_md: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == MD_WAIT) |-> !h.ex_mispredict
  );

endmodule
